rv_m_unit: RTL and testbench

RV_M_UNIT -- requirements
Module: rv_m_unit

---
 rtl/rv_m_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_rv_m_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rv_m_unit.sv
// rv_m_unit: iterative RISC-V M-extension unit covering MUL/MULH/MULHSU/MULHU
// and DIV/DIVU/REM/REMU.
//
// Multiplication is shift-add and division is restoring division on operand
// magnitudes. Both take XLEN CALC cycles, followed by one FIX cycle that applies
// the sign and selects the result half. A request accepted in cycle 0 has its
// result in cycle XLEN+2.
//
// Divide by zero and signed overflow are resolved at acceptance and go straight
// to DONE, with the result in cycle 1.
//
// Optional macro ARVI_M_DIVREM_FUSE_EN adds a fuse cache. It holds the quotient
// and remainder of the last completed divide, so a repeat DIV/REM on the same
// operands and signedness also finishes in cycle 1.
//
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_valid/o_ready  request handshake (o_ready high only in IDLE)
//   i_f3             funct3 opcode select
//   i_rs1, i_rs2     operands (rs1 = multiplicand / dividend)
//   i_kill           abort in-flight operation (ignored in IDLE)
//   o_valid/i_ready  result handshake; o_res held while waiting
//   o_res            result
module rv_m_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_res
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned PW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [2:0]      f3_q;
    logic [XLEN-1:0] hi_q, lo_q, md_q;
    logic            neg_a_q, neg_b_q;
    logic [CW-1:0]   cnt_q;

    // Request decode on the raw inputs, used only in the acceptance cycle
    logic            acc_c, is_div_c, sgn1_c, sgn2_c;
    logic            div_zero_c, div_ovf_c, bypass_c;
    logic [XLEN-1:0] mag1_c, mag2_c, bypass_res_c;
    logic            fuse_hit_c;
    logic [XLEN-1:0] fuse_res_c;

    always_comb begin
        acc_c        = (state_q == IDLE) && i_valid;
        is_div_c     = i_f3[2];
        sgn1_c       = (i_f3 == 3'b001) || (i_f3 == 3'b010) ||
                       (i_f3 == 3'b100) || (i_f3 == 3'b110);
        sgn2_c       = (i_f3 == 3'b001) || (i_f3 == 3'b100) || (i_f3 == 3'b110);
        mag1_c       = (sgn1_c && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
        mag2_c       = (sgn2_c && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;
        div_zero_c   = is_div_c && (i_rs2 == '0);
        div_ovf_c    = is_div_c && !i_f3[0] && (i_rs1 == MIN_NEG) && (i_rs2 == ALL_ONES);
        // Divide by zero takes priority; its REM result is the dividend
        if (div_zero_c) begin
            bypass_res_c = i_f3[1] ? i_rs1 : ALL_ONES;
        end else begin
            bypass_res_c = i_f3[1] ? '0 : i_rs1;
        end
        bypass_c     = div_zero_c || div_ovf_c;
    end

    // One iteration step for each algorithm
    logic [XLEN:0] mul_sum_c, div_sh_c, div_diff_c;

    always_comb begin
        mul_sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
        div_sh_c   = {hi_q, lo_q[XLEN-1]};
        div_diff_c = div_sh_c - {1'b0, md_q};
    end

    // Final sign correction and result selection
    logic [PW-1:0]   prod_c, prod_s_c;
    logic [XLEN-1:0] q_s_c, r_s_c, fix_res_c;

    always_comb begin
        prod_c   = {hi_q, lo_q};
        prod_s_c = (neg_a_q ^ neg_b_q) ? -prod_c : prod_c;
        q_s_c    = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        r_s_c    = neg_a_q ? -hi_q : hi_q;
        if (f3_q[2]) begin
            fix_res_c = f3_q[1] ? r_s_c : q_s_c;
        end else if (f3_q == 3'b000) begin
            fix_res_c = prod_s_c[XLEN-1:0];
        end else begin
            fix_res_c = prod_s_c[PW-1:XLEN];
        end
    end

`ifdef ARVI_M_DIVREM_FUSE_EN
    // Fuse cache: operands, signedness and both results of the last divide
    logic [XLEN-1:0] a_q, b_q;
    logic            fc_valid_q, fc_sgn_q;
    logic [XLEN-1:0] fc_a_q, fc_b_q, fc_q_q, fc_r_q;

    always_comb begin
        fuse_hit_c = fc_valid_q && is_div_c && (i_rs1 == fc_a_q) &&
                     (i_rs2 == fc_b_q) && (fc_sgn_q == !i_f3[0]);
        fuse_res_c = i_f3[1] ? fc_r_q : fc_q_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q        <= '0;
            b_q        <= '0;
            fc_valid_q <= 1'b0;
            fc_sgn_q   <= 1'b0;
            fc_a_q     <= '0;
            fc_b_q     <= '0;
            fc_q_q     <= '0;
            fc_r_q     <= '0;
        end else begin
            if (acc_c) begin
                a_q <= i_rs1;
                b_q <= i_rs2;
            end
            if ((state_q != IDLE) && i_kill && f3_q[2]) begin
                fc_valid_q <= 1'b0;
            end else if ((state_q == FIX) && f3_q[2]) begin
                fc_valid_q <= 1'b1;
                fc_sgn_q   <= !f3_q[0];
                fc_a_q     <= a_q;
                fc_b_q     <= b_q;
                fc_q_q     <= q_s_c;
                fc_r_q     <= r_s_c;
            end
        end
    end
`else
    always_comb begin
        fuse_hit_c = 1'b0;
        fuse_res_c = '0;
    end
`endif

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; kill wins over everything except IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = (bypass_c || fuse_hit_c) ? DONE : CALC;
                end
            end
            CALC: begin
                if (i_kill) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = i_kill ? IDLE : DONE;
            end
            DONE: begin
                if (i_kill || i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand capture and one bit per CALC cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            f3_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            md_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            cnt_q   <= '0;
        end else if (acc_c) begin
            f3_q    <= i_f3;
            hi_q    <= '0;
            lo_q    <= is_div_c ? mag1_c : mag2_c;
            md_q    <= is_div_c ? mag2_c : mag1_c;
            neg_a_q <= sgn1_c && i_rs1[XLEN-1];
            neg_b_q <= sgn2_c && i_rs2[XLEN-1];
            cnt_q   <= '0;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q + CW'(1);
            if (f3_q[2]) begin
                // Restoring divide: keep the trial difference when it does not borrow
                hi_q <= div_diff_c[XLEN] ? div_sh_c[XLEN-1:0] : div_diff_c[XLEN-1:0];
                lo_q <= {lo_q[XLEN-2:0], ~div_diff_c[XLEN]};
            end else begin
                // Shift-add: the product shifts right through hi:lo
                hi_q <= mul_sum_c[XLEN:1];
                lo_q <= {mul_sum_c[0], lo_q[XLEN-1:1]};
            end
        end
    end

    // Registered outputs follow the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_res   <= '0;
        end else begin
            o_valid <= (state_d == DONE);
            o_ready <= (state_d == IDLE);
            if ((state_q == IDLE) && (state_d == DONE)) begin
                o_res <= bypass_c ? bypass_res_c : fuse_res_c;
            end else if ((state_q == FIX) && (state_d == DONE)) begin
                o_res <= fix_res_c;
            end
        end
    end

endmodule

// File: tb/tb_rv_m_unit.sv
// tb_rv_m_unit: directed self-checking bench for rv_m_unit at XLEN=32.
// Cycle numbering: the acceptance edge ends cycle 0, so the first cycle after it is cycle 1.
module tb_rv_m_unit;

    localparam int unsigned XLEN = 32;
`ifdef ARVI_M_DIVREM_FUSE_EN
    localparam int FUSE_CYC = 1;
`else
    localparam int FUSE_CYC = 34;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [2:0]      i_f3 = 3'b000;
    logic [XLEN-1:0] i_rs1 = '0;
    logic [XLEN-1:0] i_rs2 = '0;
    logic            i_kill = 1'b0;
    logic            o_valid;
    logic            i_ready = 1'b0;
    logic [XLEN-1:0] o_res;

    int n_tests = 0;
    int n_fail  = 0;

    rv_m_unit #(.XLEN(XLEN)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_f3    (i_f3),
        .i_rs1   (i_rs1),
        .i_rs2   (i_rs2),
        .i_kill  (i_kill),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and leave the bench in cycle 1 (just after the acceptance edge)
    task automatic accept(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit kill_at_acc);
        @(negedge i_clk);
        i_f3    = f3;
        i_rs1   = a;
        i_rs2   = b;
        i_valid = 1'b1;
        i_kill  = kill_at_acc;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_kill  = 1'b0;
        // Operand changes after acceptance must not matter
        i_f3    = 3'($urandom);
        i_rs1   = $urandom;
        i_rs2   = $urandom;
    endtask

    // Full transaction: latency, result, optional stall with hold checks, drain
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cyc, input logic [31:0] exp_res,
                         input int hold, input bit kill_at_acc);
        int cyc;
        accept(f3, a, b, kill_at_acc);
        cyc = 1;
        while (!o_valid && cyc < 200) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        check({tag, "_cyc"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_res"}, 64'(o_res), 64'(exp_res));
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk);
            #1;
            check({tag, "_hold"}, {31'd0, o_valid, o_ready, o_res}, {31'd0, 1'b1, 1'b0, exp_res});
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        check({tag, "_drain"}, {62'd0, o_valid, o_ready}, 64'b01);
    endtask

    initial begin
        int seen;

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("reset", {30'd0, o_valid, o_ready, o_res}, {30'd0, 1'b0, 1'b1, 32'h0});

        // Multiply family
        do_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 0, 1'b0);
        do_op("mul_neg",    3'b000, 32'd6,         32'hFFFF_FFF9, 34, 32'hFFFF_FFD6, 0, 1'b0);
        do_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, 0, 1'b0);
        do_op("mulh_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'h0000_0000, 0, 1'b0);
        do_op("mulhu_hold", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 5, 1'b0);

        // Divide family; the second op of each pair may hit the fuse cache
        do_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         34,       32'hFFFF_FFFD, 0, 1'b0);
        do_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         FUSE_CYC, 32'hFFFF_FFFF, 0, 1'b0);
        do_op("div_7_m2",   3'b100, 32'd7,         32'hFFFF_FFFE, 34,       32'hFFFF_FFFD, 0, 1'b1);
        do_op("rem_7_m2",   3'b110, 32'd7,         32'hFFFF_FFFE, FUSE_CYC, 32'd1,         0, 1'b0);
        do_op("remu_big",   3'b111, 32'hFFFF_FFFF, 32'd16,        34,       32'd15,        0, 1'b0);

        // Special-case bypasses
        do_op("divu_zero",  3'b101, 32'd5,         32'd0,         1, 32'hFFFF_FFFF, 0, 1'b0);
        do_op("rem_zero",   3'b110, 32'hFFFF_FFF9, 32'd0,         1, 32'hFFFF_FFF9, 0, 1'b0);
        do_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 1'b0);
        do_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0, 1'b0);

        // Kill during CALC cycle 10 of a divide
        accept(3'b100, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge i_clk);
        #1;
        i_kill = 1'b1;
        @(posedge i_clk);
        #1;
        i_kill = 1'b0;
        check("kill_idle", {62'd0, o_valid, o_ready}, 64'b01);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen++;
        end
        check("kill_no_valid", 64'(seen), 64'd0);

        // Reset during CALC cycle 5
        accept(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (4) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("rst_mid", {30'd0, o_valid, o_ready, o_res}, {30'd0, 1'b0, 1'b1, 32'h0});

        // Repeated divide on the same operands
        do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 34,       32'd14, 0, 1'b0);
        do_op("remu_100_7", 3'b111, 32'd100, 32'd7, FUSE_CYC, 32'd2,  0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
